tft_rx_monitor: RTL
===================

Name: tft_rx_monitor

Overview:
- Receive-side counterpart of the TFT panel driver: decodes the DCLK/DE/R/G/B stream the driver puts on the panel bus back into an RGB565 pixel stream with X/Y coordinates.
- Checks the 800x480 geometry and raises sticky error flags when it is wrong.
- Sits on the system clock next to the panel driver. Used for on-board loopback/self-test and for bench scoreboarding against frame-buffer contents.

Parameters:
H_ACTIVE, 800, active pixels per DE run
V_ACTIVE, 480, active lines per frame
VBLANK_GAP, 1200, consecutive DCLK rising edges with DE low that mark vertical blank (must exceed the horizontal blank)

Ports:
clk  in  1  system clock (same clock that generates DCLK)
rst  in  1  reset; synchronous, active-low
DCLK  in  1  panel pixel clock, synchronous to clk
DE  in  1  data enable
R  in  6  red
G  in  6  green
B  in  6  blue
err_clr  in  1  clears sticky error flags
pix_valid  out  1  one-clk pulse per accepted pixel
pix_data  out  16  RGB565 = {R[5:1],G[5:0],B[5:1]}
pix_x  out  10  column of pix_data, 0..H_ACTIVE-1
pix_y  out  9  line of pix_data, 0..V_ACTIVE-1
frame_start  out  1  pulse with the first pixel of a frame
line_done  out  1  pulse on each DE falling sample
frame_done  out  1  pulse when vertical blank is declared
locked  out  1  high once the first vertical blank is seen
err_line_len  out  1  sticky: a DE run length differed from H_ACTIVE
err_frame_lines  out  1  sticky: line count at frame end differed from V_ACTIVE

Behaviour:
- Reset (rst low at a clk edge): every output is 0; the state machine goes to SEARCH; all counters are cleared. Reset mid-frame abandons the frame silently, with no pulses.
- Edge detect: dclk_q <= DCLK; tick = DCLK & ~dclk_q. DE and RGB are sampled in the tick cycle.
- All outputs are registered, so pix_valid and the pulse outputs rise exactly 1 clk after the tick cycle.
- gap counter: 11-bit, saturating. It counts ticks with DE=0 and clears on any tick with DE=1.
- x counter: 11-bit, saturating at 2047. y counter: 10-bit, saturating.
- States:
  - SEARCH: ignore DE and RGB. When gap reaches VBLANK_GAP, go to VBLANK and set locked=1. No frame_done pulse on this entry.
  - VBLANK: on a tick with DE=1, emit pixel (x=0, y=0), assert frame_start, set x=1, y=0, go to ACTIVE.
  - ACTIVE, tick with DE=1: if x<H_ACTIVE and y<V_ACTIVE, pix_valid=1 with the current x and y. Otherwise the sample is dropped (no pix_valid). Then x++.
  - ACTIVE, tick with DE=0: line_done=1; if x!=H_ACTIVE set err_line_len; y++; go to HBLANK.
  - HBLANK, tick with DE=1: emit at x=0 and the current y (same rule as ACTIVE); x=1; go to ACTIVE.
  - HBLANK, gap reaches VBLANK_GAP: frame_done=1; if y!=V_ACTIVE set err_frame_lines; y=0; go to VBLANK.
- Gap counting continues through HBLANK. The gap threshold is only acted on in SEARCH and HBLANK.
- Sticky flags: err_clr clears both. If a set and err_clr occur in the same cycle, the set wins. Flags survive across frames.
- locked stays high until reset.
- Non-tick cycles: pulse outputs are 0. pix_data, pix_x and pix_y hold their last values.
- DCLK stopped: state holds indefinitely; no timeout.

Optional Feature:
- Macro TFT_RX_CRC_EN.
- When defined:
  - Add output frame_crc[15:0] (CRC-16-CCITT, poly 0x1021, seed 0xFFFF, MSB-first over the 16-bit pix_data of every pix_valid in a frame).
  - Add output crc_valid[0:0], pulsed together with frame_done. frame_crc is updated in that same cycle and holds until the next frame_done.
  - The CRC state reseeds on frame_start.
- When undefined: neither port exists and no CRC logic is built.
- Reset value of frame_crc is 0x0000.

Test Plan:
- Nominal: driver-model stream with DCLK = clk/4, 800-pixel lines, 480 lines, blanks 256 and 1300 ticks, R=G=B=6'h3F -> locked after the first blank; 384000 pix_valid per frame with pix_data=16'hFFFF; last pixel at x=799, y=479; one frame_start, 480 line_done, one frame_done; both err flags 0.
- Short line: line 10 has 799 DE ticks -> err_line_len=1 after that line_done; that line has 799 pix_valid; err_frame_lines stays 0. Pulse err_clr -> flag 0; next frame leaves it 0.
- Long line and long frame: line 5 has 802 ticks and the frame has 481 lines -> pixels at x=800/801 and all of line 480 are dropped; both flags set; pix_y never exceeds 479.
- Start mid-frame: release reset while the stream is at line 200 -> no pix_valid until after the next 1200-tick gap; first frame_start has pix_y=0 and pix_x=0.
- Set/clear collision and reset mid-line: err_clr in the same cycle as a short-line detection -> flag 1. rst low during line 100 -> all outputs 0 on the next clk; returns to SEARCH.
- CRC (macro defined): two identical frames of an x-ramp pattern -> equal frame_crc on both crc_valid pulses. Corrupt one pixel in frame 3 -> frame_crc differs.

Source files
------------

// File: rtl/tft_rx_monitor.sv
// Receive-side TFT panel monitor: decodes DCLK/DE/RGB back into RGB565 pixels with X/Y and checks geometry.
// Optional frame CRC-16-CCITT output is built when TFT_RX_CRC_EN is defined.
module tft_rx_monitor #(
    parameter int H_ACTIVE   = 800,
    parameter int V_ACTIVE   = 480,
    parameter int VBLANK_GAP = 1200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        DCLK,
    input  logic        DE,
    input  logic [5:0]  R,
    input  logic [5:0]  G,
    input  logic [5:0]  B,
    input  logic        err_clr,
    output logic        pix_valid,
    output logic [15:0] pix_data,
    output logic [9:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic        frame_start,
    output logic        line_done,
    output logic        frame_done,
    output logic        locked,
    output logic        err_line_len,
    output logic        err_frame_lines
`ifdef TFT_RX_CRC_EN
    ,
    output logic [15:0] frame_crc,
    output logic [0:0]  crc_valid
`endif
);

    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_VBLANK = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;
    localparam logic [1:0] ST_HBLANK = 2'd3;

    localparam logic [10:0] H_ACT_C = 11'(H_ACTIVE);
    localparam logic [9:0]  V_ACT_C = 10'(V_ACTIVE);
    localparam logic [10:0] GAP_C   = 11'(VBLANK_GAP);

    logic        dclk_q_r;
    logic [1:0]  state_r;
    logic [10:0] gap_r;
    logic [10:0] x_r;
    logic [9:0]  y_r;

    logic        tick_s;
    logic [10:0] gap_inc_s;
    logic        gap_hit_s;
    logic [10:0] x_inc_s;
    logic [9:0]  y_inc_s;
    logic        in_win_s;
    logic [15:0] rgb565_s;
    logic        unused_lsb_s;

    logic [1:0]  state_nxt_s;
    logic [10:0] x_nxt_s;
    logic [9:0]  y_nxt_s;
    logic        emit_s;
    logic [9:0]  emit_x_s;
    logic [8:0]  emit_y_s;
    logic        fs_s;
    logic        ld_s;
    logic        fd_s;
    logic        lock_set_s;
    logic        set_line_s;
    logic        set_frame_s;

    assign tick_s       = DCLK & ~dclk_q_r;
    assign gap_inc_s    = (gap_r == 11'h7FF) ? gap_r : gap_r + 11'd1;
    assign gap_hit_s    = tick_s & ~DE & (gap_inc_s >= GAP_C);
    assign x_inc_s      = (x_r == 11'h7FF) ? x_r : x_r + 11'd1;
    assign y_inc_s      = (y_r == 10'h3FF) ? y_r : y_r + 10'd1;
    assign in_win_s     = (x_r < H_ACT_C) && (y_r < V_ACT_C);
    assign rgb565_s     = {R[5:1], G[5:0], B[5:1]};
    assign unused_lsb_s = R[0] ^ B[0];

    // Next-state, coordinate and pulse decode for the line/frame tracker.
    always_comb begin
        state_nxt_s = state_r;
        x_nxt_s     = x_r;
        y_nxt_s     = y_r;
        emit_s      = 1'b0;
        emit_x_s    = x_r[9:0];
        emit_y_s    = y_r[8:0];
        fs_s        = 1'b0;
        ld_s        = 1'b0;
        fd_s        = 1'b0;
        lock_set_s  = 1'b0;
        set_line_s  = 1'b0;
        set_frame_s = 1'b0;
        if (tick_s) begin
            case (state_r)
                ST_SEARCH: begin
                    if (gap_hit_s) begin
                        state_nxt_s = ST_VBLANK;
                        lock_set_s  = 1'b1;
                    end else begin
                        state_nxt_s = ST_SEARCH;
                    end
                end
                ST_VBLANK: begin
                    if (DE) begin
                        emit_s      = 1'b1;
                        emit_x_s    = 10'd0;
                        emit_y_s    = 9'd0;
                        fs_s        = 1'b1;
                        x_nxt_s     = 11'd1;
                        y_nxt_s     = 10'd0;
                        state_nxt_s = ST_ACTIVE;
                    end else begin
                        state_nxt_s = ST_VBLANK;
                    end
                end
                ST_ACTIVE: begin
                    if (DE) begin
                        emit_s  = in_win_s;
                        x_nxt_s = x_inc_s;
                    end else begin
                        ld_s        = 1'b1;
                        set_line_s  = (x_r != H_ACT_C);
                        y_nxt_s     = y_inc_s;
                        state_nxt_s = ST_HBLANK;
                    end
                end
                ST_HBLANK: begin
                    if (DE) begin
                        // x=0 is always inside the window, only the line can be out of range
                        emit_s      = (y_r < V_ACT_C);
                        emit_x_s    = 10'd0;
                        x_nxt_s     = 11'd1;
                        state_nxt_s = ST_ACTIVE;
                    end else if (gap_hit_s) begin
                        fd_s        = 1'b1;
                        set_frame_s = (y_r != V_ACT_C);
                        y_nxt_s     = 10'd0;
                        state_nxt_s = ST_VBLANK;
                    end else begin
                        state_nxt_s = ST_HBLANK;
                    end
                end
                default: begin
                    state_nxt_s = ST_SEARCH;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Tracker state: DCLK edge history, saturating gap counter, position counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            dclk_q_r <= 1'b0;
            state_r  <= ST_SEARCH;
            gap_r    <= 11'd0;
            x_r      <= 11'd0;
            y_r      <= 10'd0;
        end else begin
            dclk_q_r <= DCLK;
            state_r  <= state_nxt_s;
            x_r      <= x_nxt_s;
            y_r      <= y_nxt_s;
            if (tick_s) begin
                gap_r <= DE ? 11'd0 : gap_inc_s;
            end else begin
                gap_r <= gap_r;
            end
        end
    end

    // Registered pixel stream and event pulses; pixel fields hold between pixels.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pix_valid   <= 1'b0;
            pix_data    <= 16'd0;
            pix_x       <= 10'd0;
            pix_y       <= 9'd0;
            frame_start <= 1'b0;
            line_done   <= 1'b0;
            frame_done  <= 1'b0;
            locked      <= 1'b0;
        end else begin
            pix_valid   <= emit_s;
            frame_start <= fs_s;
            line_done   <= ld_s;
            frame_done  <= fd_s;
            locked      <= locked | lock_set_s;
            if (emit_s) begin
                pix_data <= rgb565_s;
                pix_x    <= emit_x_s;
                pix_y    <= emit_y_s;
            end else begin
                pix_data <= pix_data;
                pix_x    <= pix_x;
                pix_y    <= pix_y;
            end
        end
    end

    // Sticky geometry errors; a new detection beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_line_len    <= 1'b0;
            err_frame_lines <= 1'b0;
        end else begin
            err_line_len    <= set_line_s  | (err_line_len    & ~err_clr);
            err_frame_lines <= set_frame_s | (err_frame_lines & ~err_clr);
        end
    end

`ifdef TFT_RX_CRC_EN
    logic [15:0] crc_r;

    function automatic logic [15:0] crc16_ccitt(input logic [15:0] crc_in, input logic [15:0] data);
        logic [15:0] c;
        logic        fb;
        c = crc_in;
        for (int i = 15; i >= 0; i--) begin
            fb = c[15] ^ data[i];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction

    // Running frame CRC, reseeded by the first pixel of every frame and published on frame end.
    always_ff @(posedge clk) begin
        if (!rst) begin
            crc_r     <= 16'hFFFF;
            frame_crc <= 16'h0000;
            crc_valid <= 1'b0;
        end else begin
            crc_valid <= fd_s;
            if (emit_s) begin
                crc_r <= crc16_ccitt(fs_s ? 16'hFFFF : crc_r, rgb565_s);
            end else begin
                crc_r <= crc_r;
            end
            if (fd_s) begin
                frame_crc <= crc_r;
            end else begin
                frame_crc <= frame_crc;
            end
        end
    end
`endif

endmodule
